// File: rtl/hint_5_interp.sv
// hint_5_interp: 2x polyphase interpolating FIR (21-tap prototype, shift-add only).
// Each accepted 8-bit input sample produces two 20-bit outputs: the even phase
// from the updated delay line, then the odd phase from the same delay line.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   X        input sample (two's complement)
//   X_valid  X holds a valid sample
//   X_ready  block accepts X this cycle (registered)
//   Y        interpolated output sample (registered, held between strobes)
//   Y_valid  one-cycle strobe, Y is new
//   Y_phase  0 = even output y[2n], 1 = odd output y[2n+1]
module hint_5_interp (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  X,
  input  logic        X_valid,
  output logic        X_ready,
  output logic [19:0] Y,
  output logic        Y_valid,
  output logic        Y_phase
);

  localparam int unsigned WORD_SIZE_IN  = 8;
  localparam int unsigned WORD_SIZE_OUT = 20;
  localparam int unsigned TAPS          = 11;
  localparam int unsigned EXT_W         = WORD_SIZE_OUT - WORD_SIZE_IN;

  typedef logic signed [WORD_SIZE_OUT-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [WORD_SIZE_IN-1:0]   r_d [TAPS];
  logic                      r_x_ready;
  logic [WORD_SIZE_OUT-1:0]  r_y;
  logic                      r_y_valid;
  logic                      r_y_phase;

  logic                      w_accept;
  logic                      w_x_ready_nxt;
  logic [WORD_SIZE_OUT-1:0]  w_y_nxt;
  logic                      w_y_valid_nxt;
  logic                      w_y_phase_nxt;
  acc_t                      w_dx [TAPS];
  acc_t                      w_sum0;
  acc_t                      w_sum1;

  // Constant multipliers built from shifts and adds.
  function automatic acc_t f_mul7(input acc_t v);
    return (v <<< 3) - v;
  endfunction

  function automatic acc_t f_mul9(input acc_t v);
    return (v <<< 3) + v;
  endfunction

  function automatic acc_t f_mul28(input acc_t v);
    return (v <<< 5) - (v <<< 2);
  endfunction

  function automatic acc_t f_mul36(input acc_t v);
    return (v <<< 5) + (v <<< 2);
  endfunction

  function automatic acc_t f_mul105(input acc_t v);
    return (v <<< 7) - (v <<< 4) - (v <<< 3) + v;
  endfunction

  function automatic acc_t f_mul210(input acc_t v);
    return (v <<< 8) - (v <<< 6) + (v <<< 4) + (v <<< 1);
  endfunction

  assign w_accept = X_valid & r_x_ready;

  // Sign-extend the delay line to the accumulator width.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_dx[k] = {{EXT_W{r_d[k][WORD_SIZE_IN-1]}}, r_d[k]};
    end
  end

  // Both phase filters are symmetric, so taps are pre-added in mirrored pairs.
  always_comb begin
    w_sum0 = -(w_dx[0] + w_dx[10])
           + f_mul7(w_dx[1] + w_dx[9])
           - ((w_dx[2] + w_dx[8]) <<< 2)
           - f_mul36(w_dx[3] + w_dx[7])
           + f_mul105(w_dx[4] + w_dx[6])
           + (w_dx[5] <<< 8);
    w_sum1 = (w_dx[0] + w_dx[9])
           + f_mul9(w_dx[1] + w_dx[8])
           - f_mul28(w_dx[2] + w_dx[7])
           + f_mul7(w_dx[3] + w_dx[6])
           + f_mul210(w_dx[4] + w_dx[5]);
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_y_nxt       = r_y;
    w_y_valid_nxt = 1'b0;
    w_y_phase_nxt = r_y_phase;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = PH0;
      end
      PH0: begin
        w_y_nxt       = w_sum0;
        w_y_valid_nxt = 1'b1;
        w_y_phase_nxt = 1'b0;
        w_state_nxt   = PH1;
      end
      PH1: begin
        // Captures from the delay line before a concurrent shift lands.
        w_y_nxt       = w_sum1;
        w_y_valid_nxt = 1'b1;
        w_y_phase_nxt = 1'b1;
        w_state_nxt   = w_accept ? PH0 : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_x_ready_nxt = (w_state_nxt != PH0);
  end

  // State, handshake and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_x_ready <= 1'b1;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_phase <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x_ready <= w_x_ready_nxt;
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
      r_y_phase <= w_y_phase_nxt;
    end
  end

  // Delay line, shifted on each accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
    end else if (w_accept) begin
      for (int k = TAPS - 1; k > 0; k--) r_d[k] <= r_d[k-1];
      r_d[0] <= X;
    end
  end

  assign X_ready = r_x_ready;
  assign Y       = r_y;
  assign Y_valid = r_y_valid;
  assign Y_phase = r_y_phase;

endmodule

// File: tb/tb_hint_5_interp.sv
// Self-checking bench for hint_5_interp: transaction-level reference model
// (history of accepted samples convolved with the prototype taps).
module tb_hint_5_interp;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  X;
  logic        X_valid;
  logic        X_ready;
  logic [19:0] Y;
  logic        Y_valid;
  logic        Y_phase;

  hint_5_interp dut (
    .clk     (clk),
    .reset   (reset),
    .X       (X),
    .X_valid (X_valid),
    .X_ready (X_ready),
    .Y       (Y),
    .Y_valid (Y_valid),
    .Y_phase (Y_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int y;
    bit ph;
  } exp_t;

  int   h [21] = '{-1, 1, 7, 9, -4, -28, -36, 7, 105, 210, 256, 210, 105, 7,
                   -36, -28, -4, 9, 7, 1, -1};
  int   hist [11];
  exp_t q [$];
  int   cyc;
  bit   exp_ready;
  int   last_y;
  bit   last_ph;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 11; k++) hist[k] = 0;
    q.delete();
    exp_ready = 1'b1;
    last_y    = 0;
    last_ph   = 1'b0;
  endtask

  // One clock cycle: drive, clock, update model, then check outputs.
  task automatic step(input bit v, input logic [7:0] x);
    bit   acc;
    int   ev;
    int   od;
    exp_t e;
    X_valid = v;
    X       = x;
    @(posedge clk);
    cyc++;
    acc = v && exp_ready;
    if (acc) begin
      for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(x));
      ev = 0;
      od = 0;
      for (int k = 0; k < 11; k++) ev += h[2*k] * hist[k];
      for (int k = 0; k < 10; k++) od += h[2*k+1] * hist[k];
      q.push_back('{cyc + 1, ev, 1'b0});
      q.push_back('{cyc + 2, od, 1'b1});
    end
    exp_ready = !acc;
    #1;
    chk("x_ready", 32'(X_ready), 32'(exp_ready));
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("y_valid", 32'(Y_valid), 32'd1);
      chk("y", $signed(Y), 32'(e.y));
      chk("y_phase", 32'(Y_phase), 32'(e.ph));
      last_y  = e.y;
      last_ph = e.ph;
    end else begin
      chk("y_valid_idle", 32'(Y_valid), 32'd0);
      chk("y_hold", $signed(Y), 32'(last_y));
      chk("y_phase_hold", 32'(Y_phase), 32'(last_ph));
    end
  endtask

  task automatic dc_run(input logic [7:0] x, input int want);
    for (int i = 0; i < 24; i++) step(1'b1, x);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    chk("dc_final", $signed(Y), 32'(want));
  endtask

  task automatic impulse_run();
    step(1'b1, 8'd1);
    for (int i = 0; i < 42; i++) step(1'b1, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    X       = '0;
    X_valid = 1'b0;
    reset   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", $signed(Y), 32'd0);
    chk("rst_y_valid", 32'(Y_valid), 32'd0);
    chk("rst_y_phase", 32'(Y_phase), 32'd0);
    chk("rst_x_ready", 32'(X_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Impulse response reproduces the prototype taps.
    impulse_run();

    // DC gain, including the signed extremes.
    dc_run(8'd1, 398);
    dc_run(8'h80, -50944);
    dc_run(8'd127, 50546);

    // Single accept latency, then sparse pulses every 5 cycles.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)));
      for (int j = 0; j < 4; j++) step(1'b0, 8'($urandom_range(0, 255)));
    end

    // Backpressure: X changes every cycle while valid is held.
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)));

    // Random valid pattern and data.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0);

    // Reset asserted in PH0 after a large output is being held.
    dc_run(8'd127, 50546);
    step(1'b1, 8'd99);
    reset = 1'b0;
    #1;
    chk("midrst_y", $signed(Y), 32'd0);
    chk("midrst_y_valid", 32'(Y_valid), 32'd0);
    chk("midrst_x_ready", 32'(X_ready), 32'd1);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 8'd0);
    impulse_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hint_5_interp.md
# hint_5_interp

2x polyphase interpolating FIR: the transmit-side counterpart of the 21-tap decimating filter in the same filter family, using the same coefficient set. It accepts 8-bit samples through a valid/ready handshake and emits two 20-bit filtered output samples per accepted input. The output stream runs at up to the full clock rate, and the input stream at up to half the clock rate. Multiplication is shift-add only; no hardware multipliers.

## Interface
- word_size_in, 8, bit width of input X (two's complement)
- word_size_out, 20, bit width of output Y (two's complement)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- X  input  word_size_in  input sample
- X_valid  input  1  X holds a valid sample
- X_ready  output  1  block can accept X this cycle
- Y  output  word_size_out  interpolated output sample, registered
- Y_valid  output  1  one-cycle strobe: Y is new this cycle
- Y_phase  output  1  0 = even output y[2n], 1 = odd output y[2n+1]

## Operation
- Prototype coefficients h[0..20]: -1, 1, 7, 9, -4, -28, -36, 7, 105, 210, 256, 210, 105, 7, -36, -28, -4, 9, 7, 1, -1.
- Phase 0 uses the even taps h[0], h[2] … h[20], which are -1, 7, -4, -36, 105, 256, 105, -36, -4, 7, -1. Their sum is 398.
- Phase 1 uses the odd taps h[1], h[3] … h[19], which are 1, 9, -28, 7, 210, 210, 7, -28, 9, 1. Their sum is 398.
- Delay line d[0..10]: d[0] is the newest sample. On handshake (X_valid & X_ready), d[k] <= d[k-1] and d[0] <= X.
- Output equations:
  - y[2n] = sum over k=0..10 of h[2k]·d[k]
  - y[2n+1] = sum over k=0..9 of h[2k+1]·d[k]
- Constant products are formed by shift/add and sign-extended to 20 bits before summation. The worst case is 128·562 = 71936, so the result fits in 20 bits and no saturation is required.
- FSM states:
  - IDLE: X_ready=1. Handshake -> PH0.
  - PH0: X_ready=0. Register the phase-0 sum to Y with Y_phase=0 and Y_valid=1 next cycle. Always -> PH1.
  - PH1: X_ready=1. Register the phase-1 sum from the pre-shift delay line, with Y_phase=1 and Y_valid=1 next cycle. Handshake -> PH0; otherwise -> IDLE.
- In PH1 the delay-line shift and the phase-1 result capture happen on the same edge. The phase-1 result must use the delay-line contents from before the shift.
- X_ready is a registered function of state and never depends combinationally on X_valid.
- Y and Y_phase hold their last value while Y_valid=0.

## Timing
- Reset (asynchronous, active-low): state=IDLE, d[0..10]=0, Y=0, Y_valid=0, Y_phase=0, X_ready=1 once reset deasserts. Reset asserted mid-operation aborts any pending phase output immediately; no stale Y_valid follows release.
- Latency: a sample accepted at edge E0 yields the phase-0 output Y_valid at edge E0+1 and the phase-1 output at edge E0+2.
- Throughput: with X_valid held high, X_ready toggles 1,0,1,0… and Y_valid stays continuously high after the first output, with Y_phase alternating 0,1.
- Gaps: an X_valid drop during PH1 leads to IDLE. Y_valid is 0 from the cycle after the last phase-1 output until the next phase-0 output.
- X_valid high while X_ready=0 (PH0): no acceptance. X must be held by the source.

## Test plan
- Impulse: X=1, then 20 zeros, X_valid always 1 -> Y sequence -1,1,7,9,-4,-28,-36,7,105,210,256,210,105,7,-36,-28,-4,9,7,1,-1, then 0. Y_phase alternates 0,1, starting at 0.
- DC: X=1 continuously -> after 11 accepted inputs both phases give Y=398. X=-128 gives -50944; X=127 gives 50546.
- Latency/handshake: a single accept at edge E0 -> Y_valid at E0+1 (phase 0) and E0+2 (phase 1). X_ready=0 exactly during the cycle after the accept.
- Sparse input: X_valid pulsed every 5 cycles -> exactly 2 Y_valid strobes per input with no duplicates. Y holds between strobes. FSM returns to IDLE.
- Backpressure: X_valid held with X changing while X_ready=0 -> the changed value is ignored. Only values present on X_ready=1 cycles enter the delay line, checked against a reference model.
- Reset mid-stream: assert reset in PH0 -> Y=0, Y_valid=0 immediately. After release, the impulse test reproduces the exact sequence, with no residue from the delay line.
